// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: kind encodings, counter constants and the saturating counter step
package branch_predictor_pkg;
  localparam logic [1:0] KIND_COND     = 2'd0;
  localparam logic [1:0] KIND_DIRECT   = 2'd1;
  localparam logic [1:0] KIND_INDIRECT = 2'd2;
  localparam logic [1:0] KIND_RETURN   = 2'd3;
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? ((c == CTR_ST) ? c : c + 2'd1) : ((c == CTR_SNT) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack; a push when full overwrites the oldest entry
module return_addr_stack #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [RAS_DEPTH-1:0][ADDR_WIDTH-1:0] mem_q;
  logic [PW-1:0] ptr_q, ptr_d, ptr_prev, ptr_next, wr_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  assign ptr_prev = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;
  assign ptr_next = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign empty    = (cnt_q == '0);
  assign top      = mem_q[ptr_prev];
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = push;
    wr_idx = ptr_q;
    if (push && (!pop || empty)) begin
      ptr_d = ptr_next;
      cnt_d = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (push) begin
      wr_idx = ptr_prev;
    end else if (pop && !empty) begin
      ptr_d = ptr_prev;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_idx] <= push_data;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters plus a return-address stack;
// predicts at IF, learns and flags mispredicts from ID.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BTB_IDX    = 4,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [1:0]            upd_kind,
  input  logic                  upd_link,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_addr
);
  localparam int N     = 1 << BTB_IDX;
  localparam int TAG_W = ADDR_WIDTH - BTB_IDX - 2;
  logic [N-1:0]                 valid_q, valid_d;
  logic [N-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [N-1:0][ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [N-1:0][1:0]            ctr_q, ctr_d, kind_q, kind_d;
  logic [BTB_IDX-1:0]           l_idx, u_idx;
  logic [TAG_W-1:0]             l_tag, u_tag;
  logic                         l_hit, u_hit, commit, ras_empty;
  logic [ADDR_WIDTH-1:0]        ras_top, link_addr;
  logic                         unused;
  assign unused    = &{1'b0, if_pc[1:0]};
  assign l_idx     = if_pc[BTB_IDX+1:2];
  assign l_tag     = if_pc[ADDR_WIDTH-1:BTB_IDX+2];
  assign u_idx     = upd_pc[BTB_IDX+1:2];
  assign u_tag     = upd_pc[ADDR_WIDTH-1:BTB_IDX+2];
  assign l_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign commit    = upd_valid && !stall;
  assign link_addr = upd_pc + ADDR_WIDTH'(8);
  assign pred_taken  = l_hit && (kind_q[l_idx] != KIND_COND || ctr_q[l_idx][1]);
  assign pred_target = !pred_taken ? '0 :
                       (kind_q[l_idx] == KIND_RETURN && !ras_empty) ? ras_top : tgt_q[l_idx];
  assign mispredict    = upd_valid && (upd_taken != upd_pred_taken ||
                                       (upd_taken && upd_target != upd_pred_target));
  assign redirect_addr = !mispredict ? '0 : upd_taken ? upd_target : link_addr;
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    kind_d  = kind_q;
    if (commit && (u_hit || upd_taken)) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      ctr_d[u_idx]   = (upd_kind != KIND_COND) ? CTR_ST :
                       u_hit ? ctr_next(ctr_q[u_idx], upd_taken) : CTR_WT;
      if (upd_taken) begin
        tgt_d[u_idx]  = upd_target;
        kind_d[u_idx] = upd_kind;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
      kind_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      kind_q  <= kind_d;
    end
  end
  return_addr_stack #(.ADDR_WIDTH(ADDR_WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (commit && upd_link),
    .pop       (commit && upd_kind == KIND_RETURN),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );
endmodule
